// File: rtl/bus_dma_master.sv
// bus_dma_master: word-copy DMA engine acting as a second initiator on the system bus.
// Copies len_words 32-bit words from src_addr to dst_addr, one RD/WR pair per word.
// Optional build macro DMA_FILL_EN adds fill_mode/fill_data ports: the engine then writes
// a constant pattern to the destination at one word per cycle instead of copying.
module bus_dma_master #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
`ifdef DMA_FILL_EN
    input  logic             fill_mode,
    input  logic [31:0]      fill_data,
`endif
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             bus_req,
    input  logic             bus_gnt,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wdata,
    output logic [3:0]       bus_wmask,
    output logic             bus_wen,
    input  logic [31:0]      bus_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] cnt_q;
    logic             fill_q;
    logic [31:0]      fill_data_q;

    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             bus_req_q;
    logic [31:0]      bus_addr_q;
    logic [31:0]      bus_wdata_q;
    logic [3:0]       bus_wmask_q;
    logic             bus_wen_q;

    logic             fill_mode_c;
    logic [31:0]      fill_data_c;
    logic             bad_align_c;
    logic [31:0]      src_nxt_d;
    logic [31:0]      dst_nxt_d;
    logic [LEN_W-1:0] cnt_nxt_d;
    logic             last_c;

    // Fill-mode inputs collapse to constants in the copy-only build
`ifdef DMA_FILL_EN
    assign fill_mode_c = fill_mode;
    assign fill_data_c = fill_data;
`else
    assign fill_mode_c = 1'b0;
    assign fill_data_c = 32'h0;
`endif

    // Alignment check on request and per-word pointer/count advance
    always_comb begin
        bad_align_c = (dst_addr[1:0] != 2'b00) || (!fill_mode_c && (src_addr[1:0] != 2'b00));
        src_nxt_d   = src_q + 32'd4;
        dst_nxt_d   = dst_q + 32'd4;
        cnt_nxt_d   = cnt_q - LEN_W'(1);
        last_c      = (cnt_q == LEN_W'(1));
    end

    // Transfer FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            fill_q      <= 1'b0;
            fill_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
            bus_wen_q   <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
            bus_wen_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q    <= 1'b0;
                    bus_req_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (bad_align_c) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (len_words == '0) begin
                            err_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            err_q       <= 1'b0;
                            src_q       <= src_addr;
                            dst_q       <= dst_addr;
                            cnt_q       <= len_words;
                            fill_q      <= fill_mode_c;
                            fill_data_q <= fill_data_c;
                            bus_req_q   <= 1'b1;
                            state_q     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    busy_q    <= 1'b1;
                    bus_req_q <= 1'b1;
                    if (bus_gnt) begin
                        if (fill_q) begin
                            bus_addr_q  <= dst_q;
                            bus_wdata_q <= fill_data_q;
                            bus_wmask_q <= 4'hF;
                            bus_wen_q   <= 1'b1;
                            state_q     <= S_WR;
                        end else begin
                            bus_addr_q <= src_q;
                            state_q    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    // Read data is captured straight into the write-data register
                    busy_q      <= 1'b1;
                    bus_req_q   <= 1'b1;
                    bus_addr_q  <= dst_q;
                    bus_wdata_q <= bus_rdata;
                    bus_wmask_q <= 4'hF;
                    bus_wen_q   <= 1'b1;
                    state_q     <= S_WR;
                end
                S_WR: begin
                    busy_q <= 1'b1;
                    src_q  <= src_nxt_d;
                    dst_q  <= dst_nxt_d;
                    cnt_q  <= cnt_nxt_d;
                    if (last_c) begin
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end else if (bus_gnt) begin
                        bus_req_q <= 1'b1;
                        if (fill_q) begin
                            bus_addr_q  <= dst_nxt_d;
                            bus_wdata_q <= fill_data_q;
                            bus_wmask_q <= 4'hF;
                            bus_wen_q   <= 1'b1;
                            state_q     <= S_WR;
                        end else begin
                            bus_addr_q <= src_nxt_d;
                            state_q    <= S_RD;
                        end
                    end else begin
                        bus_req_q <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_DONE: begin
                    busy_q    <= 1'b0;
                    bus_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    busy_q    <= 1'b0;
                    bus_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign bus_req   = bus_req_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wmask = bus_wmask_q;
    assign bus_wen   = bus_wen_q;

endmodule
